cache_fill_fsm: RTL and testbench



---
 rtl/cache_pkg.sv | 14 +
 rtl/fill_counter.sv | 28 ++
 rtl/cache_fill_fsm.sv | 124 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache fill types and block geometry constants
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    FILL = 2'd2
  } fill_state_t;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int WORD_CNT_W      = 4;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - word counter with clear, enable and saturation at one block
module fill_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_en,
  output logic [WORD_CNT_W-1:0] o_count,
  output logic                  o_done
);

  localparam logic [WORD_CNT_W-1:0] LP_MAX = WORD_CNT_W'(WORDS_PER_BLOCK);

  logic [WORD_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != LP_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == LP_MAX);

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss handler: tag write then 8-word block fill from memory
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              write_tag_array,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_data,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid
);

  localparam logic [WORD_CNT_W-1:0] LP_LAST = WORD_CNT_W'(WORDS_PER_BLOCK - 1);

  fill_state_t           r_state;
  fill_state_t           w_next_state;
  logic [ADDR_W-1:0]     r_base;

  logic                  w_cnt_clear;
  logic                  w_issue_en;
  logic                  w_recv_en;
  logic                  w_issue_done;
  logic                  w_recv_done;
  logic                  w_last_word;
  logic [WORD_CNT_W-1:0] w_issue_cnt;
  logic [WORD_CNT_W-1:0] w_recv_cnt;
  logic [ADDR_W-1:0]     w_issue_addr;
  logic [ADDR_W-1:0]     w_recv_addr;

  // Counters restart in TAG so each fill begins from word 0.
  assign w_cnt_clear = (r_state == TAG);
  assign w_issue_en  = (r_state == FILL) && !w_issue_done;
  assign w_recv_en   = (r_state == FILL) && memory_data_valid && !w_recv_done;
  assign w_last_word = w_recv_en && (w_recv_cnt == LP_LAST);

  assign w_issue_addr = r_base + {{(ADDR_W-WORD_CNT_W-1){1'b0}}, w_issue_cnt, 1'b0};
  assign w_recv_addr  = r_base + {{(ADDR_W-WORD_CNT_W-1){1'b0}}, w_recv_cnt, 1'b0};

  fill_counter u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clear),
    .i_en    (w_issue_en),
    .o_count (w_issue_cnt),
    .o_done  (w_issue_done)
  );

  fill_counter u_recv_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clear),
    .i_en    (w_recv_en),
    .o_count (w_recv_cnt),
    .o_done  (w_recv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && miss_detected) begin
        r_base <= {miss_address[ADDR_W-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    fsm_busy         = 1'b0;
    write_tag_array  = 1'b0;
    write_data_array = 1'b0;
    cache_address    = '0;
    cache_data       = '0;
    memory_read      = 1'b0;
    memory_address   = '0;
    case (r_state)
      IDLE: begin
        // Stall must reach the pipeline in the same cycle the miss is seen.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          w_next_state = TAG;
        end
      end
      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        cache_address   = r_base;
        w_next_state    = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (w_issue_en) begin
          memory_read    = 1'b1;
          memory_address = w_issue_addr;
        end
        if (w_recv_en) begin
          write_data_array = 1'b1;
          cache_address    = w_recv_addr;
          cache_data       = memory_data;
        end
        if (w_last_word) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - scoreboard bench for cache_fill_fsm with a latency-L memory model
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        fsm_busy;
  logic        write_tag_array;
  logic        write_data_array;
  logic [15:0] cache_address;
  logic [15:0] cache_data;
  logic        memory_read;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;

  logic        mem_valid = 1'b0;
  logic [15:0] mem_word = 16'h0;
  logic        spur_valid = 1'b0;
  logic [15:0] spur_word = 16'hDEAD;

  assign memory_data_valid = mem_valid | spur_valid;
  assign memory_data       = spur_valid ? spur_word : mem_word;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  resp_t       pend[$];
  logic [15:0] exp_tag[$];
  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 4;
  int          rd_idx = 0;
  logic [15:0] word_base = 16'h0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .write_tag_array   (write_tag_array),
    .write_data_array  (write_data_array),
    .cache_address     (cache_address),
    .cache_data        (cache_data),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected strobe expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    logic [15:0] e;
    wr_t         w;
    if (write_tag_array === 1'b1) begin
      if (exp_tag.size() == 0) unexpected("tag_write");
      else begin
        e = exp_tag.pop_front();
        chk("tag_addr", 64'(cache_address), 64'(e));
      end
    end
    if (memory_read === 1'b1) begin
      if (exp_rd.size() == 0) unexpected("mem_read");
      else begin
        e = exp_rd.pop_front();
        chk("rd_addr", 64'(memory_address), 64'(e));
      end
    end
    if (write_data_array === 1'b1) begin
      if (exp_wr.size() == 0) unexpected("data_write");
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(cache_address), 64'(w.a));
        chk("wr_data", 64'(cache_data), 64'(w.d));
      end
    end
  end

  // Memory model: each accepted read returns word_base+index exactly lat cycles later.
  always @(negedge clk) begin
    if (memory_read === 1'b1) begin
      pend.push_back('{cyc + lat, 16'(word_base + 16'(rd_idx))});
      rd_idx++;
    end
  end

  always @(posedge clk) begin
    resp_t r;
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r         = pend.pop_front();
      mem_valid = 1'b1;
      mem_word  = r.data;
    end else begin
      mem_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      @(negedge clk);
      chk("idle_outputs",
          64'({fsm_busy, write_tag_array, write_data_array, memory_read,
               cache_address, cache_data, memory_address}), 64'(0));
    end
  endtask

  // Called at cycle 0 of a miss; returns after the busy check of cycle last_k.
  task automatic fill_body(input logic [15:0] addr, input int l, input logic [15:0] wb,
                           input int last_k, input bit spur_tag);
    logic [15:0] b;
    b = {addr[15:4], 4'h0};
    chk("leftover_tag", 64'(exp_tag.size()), 64'(0));
    chk("leftover_rd", 64'(exp_rd.size()), 64'(0));
    chk("leftover_wr", 64'(exp_wr.size()), 64'(0));
    lat       = l;
    word_base = wb;
    rd_idx    = 0;
    exp_tag.push_back(b);
    for (int k = 0; k < 8; k++) begin
      exp_rd.push_back(16'(b + 16'(2 * k)));
      exp_wr.push_back('{16'(b + 16'(2 * k)), 16'(wb + 16'(k))});
    end
    miss_detected = 1'b1;
    miss_address  = addr;
    @(negedge clk);
    chk("busy_miss_cycle", 64'(fsm_busy), 64'(1));
    for (int k = 1; k <= last_k; k++) begin
      step();
      miss_detected = 1'b0;
      spur_valid    = spur_tag && (k == 1);
      @(negedge clk);
      chk("busy_during_fill", 64'(fsm_busy), 64'(1));
    end
    spur_valid = 1'b0;
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle_check(20);

    // Basic fill, L=4: last write at cycle 13, IDLE at cycle 14
    step();
    fill_body(16'h1236, 4, 16'hA000, 13, 1'b0);
    idle_check(3);

    // Minimum latency L=1 near top of address space: IDLE at cycle 11
    step();
    fill_body(16'hFFF2, 1, 16'hB000, 10, 1'b0);
    idle_check(2);

    // Spurious valid in IDLE, in TAG, and a 9th valid after the last word
    step();
    spur_valid = 1'b1;
    @(negedge clk);
    chk("spur_idle_outputs", 64'({fsm_busy, write_data_array}), 64'(0));
    step();
    spur_valid = 1'b0;
    fill_body(16'h0106, 2, 16'hC000, 11, 1'b1);
    step();
    spur_valid = 1'b1;
    @(negedge clk);
    chk("ninth_valid_outputs", 64'({fsm_busy, write_data_array, cache_address}), 64'(0));
    step();
    spur_valid = 1'b0;
    idle_check(2);

    // Reset mid-fill after the 3rd word is written (cycle 8), responses still in flight
    step();
    fill_body(16'h0500, 4, 16'hD000, 7, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    chk("after_reset_outputs",
        64'({fsm_busy, write_tag_array, write_data_array, memory_read,
             cache_address, cache_data, memory_address}), 64'(0));
    idle_check(5);
    chk("responses_drained", 64'(pend.size()), 64'(0));

    // New fill after reset, L=3: IDLE at cycle 13
    step();
    fill_body(16'h0040, 3, 16'hE000, 12, 1'b0);

    // Back-to-back miss on the first IDLE cycle
    step();
    fill_body(16'h2000, 2, 16'hF000, 11, 1'b0);
    idle_check(3);
    chk("final_tag_empty", 64'(exp_tag.size()), 64'(0));
    chk("final_rd_empty", 64'(exp_rd.size()), 64'(0));
    chk("final_wr_empty", 64'(exp_wr.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
